// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : instr_loader_pkg
// Purpose : Shared types and constants for the instruction memory loader.
//           Holds the loader state encoding and the header/word byte counts.
// Revision: 1.0  initial release
// ============================================================================
package instr_loader_pkg;

  // Loader state machine encoding
  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Header and payload words are both 4 bytes, so one packer serves both
  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage : instr_loader_pkg
`default_nettype wire

// File: rtl/instr_mem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer
// Purpose : Assembles a little-endian 32-bit word from a stream of bytes.
//           The first byte of a word lands in bits [7:0].
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           clr_i         - synchronous clear of counter and partial word
//           en_i          - a byte is accepted this cycle
//           byte_i        - accepted byte
//           word_full_o   - this byte completes a word (combinational)
//           word_o        - word including the current byte (combinational)
// Revision: 1.0  initial release
// ============================================================================
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_full_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] C_LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic [31:0] word_d;

  // New bytes enter from the top, so after four shifts the first byte
  // has walked down to bits [7:0].
  assign word_d      = {byte_i, word_q[31:8]};
  assign word_o      = word_d;
  assign word_full_o = en_i && (cnt_q == C_LAST_BYTE);

  // Nothing is cleared when en_i is low, so partial words survive any gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clr_i) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (en_i) begin
      cnt_q  <= cnt_q + 2'd1;  // wraps to 0 after the last byte of a word
      word_q <= word_d;
    end
  end

endmodule : byte_packer
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_loader
// Purpose : Receives a program as a byte stream (4-byte LE word count N,
//           then N LE words) and writes it to instruction memory at word
//           addresses 0..N-1. Holds the core in reset until the load is done.
// Ports   : clk, rst                 - clock, asynchronous active-high reset
//           in_valid/in_data/in_ready - byte stream handshake
//           reload                   - restart a load from DONE or ERR
//           mem_we/mem_addr/mem_wdata - instruction memory write port
//           core_rst                 - active-low core reset (1 = released)
//           done, error              - load complete / N exceeds DEPTH
//           words_loaded             - words written so far
// Revision: 1.0  initial release
// ============================================================================
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic              accept;
  logic              clr;
  logic              word_full;
  logic [31:0]       word;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  words_loaded_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  assign in_ready = !rst && ((state_q == ST_HDR) || (state_q == ST_DATA));
  assign accept   = in_valid && in_ready;
  assign clr      = reload && ((state_q == ST_DONE) || (state_q == ST_ERR));

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .en_i        (accept),
    .byte_i      (in_data),
    .word_full_o (word_full),
    .word_o      (word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_HDR;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (word_full) begin
          // Full 32-bit compare so counts with high bits set are rejected
          if (word == 32'd0)               state_d = ST_DONE;
          else if (word > 32'(DEPTH))      state_d = ST_ERR;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if ((words_loaded_q + CNT_W'(1)) == n_q) state_d = ST_DONE;
        else                                     state_d = ST_DATA;
      end
      ST_DONE, ST_ERR: begin
        if (reload) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  // Word count, header latch and registered memory-write outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q            <= '0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'd0;
    end else begin
      // The write strobe is raised for the WRITE cycle that follows the
      // last byte of a payload word; it cannot repeat since DATA must
      // collect four fresh bytes first.
      mem_we_q <= (state_q == ST_DATA) && word_full;
      if ((state_q == ST_DATA) && word_full) begin
        mem_addr_q  <= words_loaded_q[ADDR_W-1:0];
        mem_wdata_q <= word;
      end
      // Only counts <= DEPTH ever reach DATA, so CNT_W bits hold N exactly
      if ((state_q == ST_HDR) && word_full) begin
        n_q <= word[CNT_W-1:0];
      end
      if (clr) begin
        words_loaded_q <= '0;
      end else if (state_q == ST_WRITE) begin
        words_loaded_q <= words_loaded_q + CNT_W'(1);
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = {{(32-ADDR_W){1'b0}}, mem_addr_q};
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_loaded_q;
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign core_rst     = (state_q == ST_DONE);

endmodule : instr_mem_loader
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_mem_loader
// Purpose : Directed self-checking bench for instr_mem_loader. One instance
//           uses DEPTH=1024, a second uses DEPTH=4 for the full-memory case.
// Revision: 1.0  initial release
// ============================================================================
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        v, v4;
  logic [7:0]  in_data;
  logic        reload;

  logic        rdy, we, crst, dn, err;
  logic [31:0] addr, wdata;
  logic [10:0] wl;

  logic        rdy4, we4, crst4, dn4, err4;
  logic [31:0] addr4, wdata4;
  logic [2:0]  wl4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(v), .in_data(in_data), .in_ready(rdy),
    .reload(reload), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
    .core_rst(crst), .done(dn), .error(err), .words_loaded(wl)
  );

  instr_mem_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(in_data), .in_ready(rdy4),
    .reload(reload), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .core_rst(crst4), .done(dn4), .error(err4), .words_loaded(wl4)
  );

  // Write log and write-port invariants, sampled on the falling edge
  logic [31:0] la [0:15];
  logic [31:0] ld [0:15];
  logic [31:0] la4[0:15];
  logic [31:0] ld4[0:15];
  int ln = 0, ln4 = 0, b2b = 0, bad_addr = 0;
  logic pwe = 1'b0, pwe4 = 1'b0;

  always @(negedge clk) begin
    if (we) begin
      if (ln < 16) begin la[ln] = addr; ld[ln] = wdata; end
      ln++;
      if (addr >= 32'd1024) bad_addr++;
    end
    if (we4) begin
      if (ln4 < 16) begin la4[ln4] = addr4; ld4[ln4] = wdata4; end
      ln4++;
      if (addr4 >= 32'd4) bad_addr++;
    end
    if (we && pwe)   b2b++;
    if (we4 && pwe4) b2b++;
    pwe  = we;
    pwe4 = we4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input bit sel, input logic [7:0] b);
    bit ok = 1'b0;
    in_data = b;
    if (sel) v4 = 1'b1; else v = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if ((sel ? rdy4 : rdy) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    v  = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(sel, w[8*i +: 8]);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  int bad_ready;
  int prev_ln;
  logic [31:0] gw;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; v = 1'b0; v4 = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_in_ready", {31'd0, rdy}, 32'd0);
    chk("rst_mem_we",   {31'd0, we}, 32'd0);
    chk("rst_mem_addr", addr, 32'd0);
    chk("rst_mem_wdata", wdata, 32'd0);
    chk("rst_flags", {29'd0, dn, err, crst}, 32'd0);
    chk("rst_words", {21'd0, wl}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("hdr_in_ready", {31'd0, rdy}, 32'd1);

    // Two-word load
    send_word(1'b0, 32'd2);
    send_word(1'b0, 32'h00500013);
    send_word(1'b0, 32'h00100093);
    chk("last_we", {31'd0, we}, 32'd1);
    chk("last_addr", addr, 32'd1);
    chk("last_wdata", wdata, 32'h00100093);
    chk("pre_done_flags", {30'd0, dn, crst}, 32'd0);
    chk("write_in_ready", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    chk("done_flags", {30'd0, dn, crst}, 32'd3);
    chk("words_2", {21'd0, wl}, 32'd2);
    chk("n_writes_2", ln, 32'd2);
    chk("w0_addr", la[0], 32'd0);
    chk("w0_data", ld[0], 32'h00500013);
    chk("w1_data", ld[1], 32'h00100093);
    chk("done_in_ready", {31'd0, rdy}, 32'd0);

    // Reload, then an empty program
    pulse_reload();
    chk("reload_in_ready", {31'd0, rdy}, 32'd1);
    chk("reload_flags", {29'd0, dn, err, crst}, 32'd0);
    chk("reload_words", {21'd0, wl}, 32'd0);
    send_word(1'b0, 32'd0);
    chk("empty_done", {30'd0, dn, crst}, 32'd3);
    @(negedge clk);
    chk("empty_no_write", ln, 32'd2);

    // Oversized count
    pulse_reload();
    send_word(1'b0, 32'h00000401);
    chk("big_error", {29'd0, err, dn, crst}, 32'd4);
    chk("big_in_ready", {31'd0, rdy}, 32'd0);
    bad_ready = 0;
    v = 1'b1; in_data = 8'h55;
    repeat (3) begin @(negedge clk); if (rdy) bad_ready++; end
    v = 1'b0;
    chk("err_ignores_stream", bad_ready, 32'd0);
    chk("err_still_error", {31'd0, err}, 32'd1);
    chk("big_no_write", ln, 32'd2);
    pulse_reload();
    chk("err_reload", {30'd0, err, rdy}, 32'd1);
    // Count with only high bits set must also be rejected
    send_word(1'b0, 32'h80000000);
    chk("high_bit_error", {30'd0, err, dn}, 32'd2);

    // Single word with random idle gaps
    pulse_reload();
    bad_ready = 0;
    prev_ln = ln;
    gw = 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, (i < 4) ? ((i == 0) ? 8'd1 : 8'd0) : gw[8*(i-4) +: 8]);
      if (i != 7) begin
        repeat ($urandom_range(0, 7)) begin
          @(negedge clk);
          if (!rdy) bad_ready++;
        end
      end
    end
    chk("gap_we", {31'd0, we}, 32'd1);
    chk("gap_write_in_ready", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    chk("gap_done", {31'd0, dn}, 32'd1);
    chk("gap_ready_in_gaps", bad_ready, 32'd0);
    chk("gap_one_write", ln - prev_ln, 32'd1);
    chk("gap_addr", la[prev_ln], 32'd0);
    chk("gap_data", ld[prev_ln], 32'h12345678);

    // Reset in the middle of a payload word
    pulse_reload();
    prev_ln = ln;
    send_word(1'b0, 32'd1);
    send(1'b0, 8'hAA);
    send(1'b0, 8'hBB);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, rdy}, 32'd0);
    chk("midrst_words", {21'd0, wl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(1'b0, 32'd1);
    send_word(1'b0, 32'hDDCCBBAA);
    @(negedge clk);
    chk("midrst_done", {31'd0, dn}, 32'd1);
    chk("midrst_one_write", ln - prev_ln, 32'd1);
    chk("midrst_addr", la[prev_ln], 32'd0);
    chk("midrst_data", ld[prev_ln], 32'hDDCCBBAA);

    // DEPTH=4 instance filled completely
    send_word(1'b1, 32'd4);
    for (int i = 0; i < 4; i++) send_word(1'b1, 32'hC0DE0000 | i);
    @(negedge clk);
    chk("d4_done", {30'd0, dn4, crst4}, 32'd3);
    chk("d4_words", {29'd0, wl4}, 32'd4);
    chk("d4_n_writes", ln4, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d4_addr%0d", i), la4[i], i);
      chk($sformatf("d4_data%0d", i), ld4[i], 32'hC0DE0000 | i);
    end
    bad_ready = 0;
    v4 = 1'b1; in_data = 8'h77;
    repeat (3) begin @(negedge clk); if (rdy4) bad_ready++; end
    v4 = 1'b0;
    @(negedge clk);
    chk("d4_ignore_after_done", bad_ready, 32'd0);
    chk("d4_no_extra_write", ln4, 32'd4);
    chk("d4_words_hold", {29'd0, wl4}, 32'd4);

    chk("we_back_to_back", b2b, 32'd0);
    chk("addr_in_range", bad_addr, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_mem_loader
`default_nettype wire
